// File: rtl/reservoir_pkg.sv
// Shared encodings and widths for the reservoir sampling path.
// State encoding is fixed because the reservoir controller decodes it.
package reservoir_pkg;

  localparam int unsigned ByteW    = 8;
  localparam int unsigned BitCntW  = 3;
  localparam int unsigned ByteCntW = 8;
  localparam int unsigned DivW     = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSample = 2'd1,
    StDrain  = 2'd2
  } sampler_state_e;

  // Place one sample into its LSB-first slot of the byte being assembled.
  function automatic logic [ByteW-1:0] pack_bit(input logic [ByteW-1:0]   cur,
                                                input logic [BitCntW-1:0] idx,
                                                input logic               b);
    logic [ByteW-1:0] res;
    res      = cur;
    res[idx] = b;
    return res;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock byte FIFO; a push into a full FIFO is accepted only with a simultaneous pop.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module sample_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AddrW+1)'(Depth));
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so the output idles at its reset value.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AddrW+1)'(1);
      2'b01:   count_d = count_q - (AddrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dynamics_sampler.sv
// Samples the reservoir output node into LSB-first bytes and streams them to the serial transmitter.
// Define DYNAMICS_SAMPLER_SYNC_EN to insert a 2-flop synchronizer on dynamics (2 samples of latency).
module dynamics_sampler
  import reservoir_pkg::*;
#(
  parameter int unsigned N_BYTES    = 32,
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             dynamics,
  input  logic             collect_dynamics,
  output logic [ByteW-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  sampler_state_e state_q, state_d;

  logic                  collect_q;
  logic                  start;
  logic                  sample_bit;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ByteW-1:0]      shift_q, shift_d, shift_nxt;
  logic                  overflow_q, overflow_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef DYNAMICS_SAMPLER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], dynamics};
    end
  end

  assign sample_bit = sync_q[1];
`else
  // Direct capture keeps the bit stream aligned with the reservoir model.
  assign sample_bit = dynamics;
`endif

  assign start     = collect_dynamics & ~collect_q;
  assign shift_nxt = pack_bit(shift_q, bit_cnt_q, sample_bit);
  assign fifo_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;
  assign busy      = (state_q != StIdle);
  assign overflow  = overflow_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSample;
          div_d      = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          overflow_d = 1'b0;
        end
      end

      StSample: begin
        if (div_q == '0) begin
          div_d     = DivW'(SAMPLE_DIV - 1);
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == BitCntW'(ByteW - 1)) begin
            fifo_push  = 1'b1;
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
            // A dropped byte still counts toward the run length.
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
            if (byte_cnt_q == ByteCntW'(N_BYTES - 1)) state_d = StDrain;
          end
        end else begin
          div_d = div_q - DivW'(1);
        end
      end

      StDrain: begin
        if (fifo_count == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      collect_q  <= 1'b0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      collect_q  <= collect_dynamics;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ByteW)
  ) u_fifo (
    .clk   (fast_clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (shift_nxt),
    .pop   (fifo_pop),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_dynamics_sampler.sv
// Self-checking bench for dynamics_sampler: three instances cover the single-byte pattern,
// divided sampling and the 20-byte FIFO/overflow/reset/retrigger scenarios.
module tb_dynamics_sampler;

`ifdef DYNAMICS_SAMPLER_SYNC_EN
  localparam int unsigned Lat = 2;
  localparam logic [7:0]  PatByte = 8'h34;
`else
  localparam int unsigned Lat = 0;
  localparam logic [7:0]  PatByte = 8'h8D;
`endif

  logic       fast_clk;
  logic       reset;
  logic       dynamics;
  logic       collect_a, collect_b, collect_c;
  logic       tx_ready_a, tx_ready_b, tx_ready_c;
  logic [7:0] tx_data_a, tx_data_b, tx_data_c;
  logic       tx_valid_a, tx_valid_b, tx_valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       overflow_a, overflow_b, overflow_c;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] hist;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  dynamics_sampler #(.N_BYTES(1), .SAMPLE_DIV(1), .FIFO_DEPTH(16)) u_a (
    .fast_clk(fast_clk), .reset(reset), .dynamics(dynamics), .collect_dynamics(collect_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a),
    .done(done_a), .overflow(overflow_a));

  dynamics_sampler #(.N_BYTES(2), .SAMPLE_DIV(4), .FIFO_DEPTH(16)) u_b (
    .fast_clk(fast_clk), .reset(reset), .dynamics(dynamics), .collect_dynamics(collect_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b),
    .done(done_b), .overflow(overflow_b));

  dynamics_sampler #(.N_BYTES(20), .SAMPLE_DIV(1), .FIFO_DEPTH(16)) u_c (
    .fast_clk(fast_clk), .reset(reset), .dynamics(dynamics), .collect_dynamics(collect_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .busy(busy_c),
    .done(done_c), .overflow(overflow_c));

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  // Returns the bit the DUT will capture for the value driven this cycle.
  task automatic drive_bit(input logic b, output logic e);
    e        = (Lat == 0) ? b : hist[1];
    hist     = {hist[0], b};
    dynamics = b;
  endtask

  task automatic idle_low();
    dynamics = 1'b0;
    repeat (3) tick();
    hist = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({tx_valid_a, tx_data_a, busy_a, done_a, overflow_a} !== 12'h0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", {tx_valid_a, tx_data_a, busy_a, done_a, overflow_a});
    end
    checks++;
    if ({tx_valid_b, tx_data_b, busy_b, done_b, overflow_b} !== 12'h0) begin
      errors++;
      $display("FAIL reset_b got %h want 0", {tx_valid_b, tx_data_b, busy_b, done_b, overflow_b});
    end
    checks++;
    if ({tx_valid_c, tx_data_c, busy_c, done_c, overflow_c} !== 12'h0) begin
      errors++;
      $display("FAIL reset_c got %h want 0", {tx_valid_c, tx_data_c, busy_c, done_c, overflow_c});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    logic [7:0] exp_byte;
    logic [7:0] want;
    logic       e;
    pat        = 8'b1000_1101;
    exp_byte   = 8'h00;
    tx_ready_a = 1'b1;
    idle_low();
    collect_a = 1'b1;
    tick();
    collect_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_bit(pat[k], e);
      exp_byte[k] = e;
      checks++;
      if (busy_a !== 1'b1 || tx_valid_a !== 1'b0) begin
        errors++;
        $display("FAIL pat_sampling k=%0d got busy=%b valid=%b want 1 0", k, busy_a, tx_valid_a);
      end
      tick();
    end
    q_a.push_back(exp_byte);
    dynamics = 1'b0;
    want     = q_a.pop_front();
    checks++;
    if (tx_valid_a !== 1'b1 || tx_data_a !== want) begin
      errors++;
      $display("FAIL pat_byte got valid=%b data=%h want 1 %h", tx_valid_a, tx_data_a, want);
    end
    checks++;
    if (tx_data_a !== PatByte) begin
      errors++;
      $display("FAIL pat_literal got %h want %h", tx_data_a, PatByte);
    end
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL pat_done_early got %b want 0", done_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1 || tx_valid_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pat_done got done=%b valid=%b busy=%b want 1 0 1", done_a, tx_valid_a,
               busy_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL pat_idle got done=%b busy=%b want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_sample_div();
    int busy_cnt;
    int done_cnt;
    int cyc;
    logic [7:0] want;
    busy_cnt   = 0;
    done_cnt   = 0;
    dynamics   = 1'b1;
    tx_ready_b = 1'b1;
    repeat (3) tick();
    q_b.push_back(8'hFF);
    q_b.push_back(8'hFF);
    collect_b = 1'b1;
    tick();
    collect_b = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (!busy_b) break;
      busy_cnt++;
      if (done_b) done_cnt++;
      if (tx_valid_b && tx_ready_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL div_extra_byte got %h want none", tx_data_b);
        end else begin
          want = q_b.pop_front();
          if (tx_data_b !== want) begin
            errors++;
            $display("FAIL div_byte got %h want %h", tx_data_b, want);
          end
        end
      end
      tick();
    end
    dynamics = 1'b0;
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL div_timeout got busy after %0d cycles want idle", cyc);
    end
    // 1 + 15*4 sampling cycles, one cycle to pop the last byte, one done cycle.
    checks++;
    if (busy_cnt != 63) begin
      errors++;
      $display("FAIL div_busy_cycles got %0d want 63", busy_cnt);
    end
    checks++;
    if (q_b.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL div_complete got left=%0d done=%0d want 0 1", q_b.size(), done_cnt);
    end
  endtask

  // ready_mode: 0 stall until cycle 180, 1 always ready, 2 random ready.
  task automatic run_c(input int ready_mode, input int retrig, input int rst_at,
                       output int popped);
    int         cnt;
    int         cnt_pre;
    bit         ovf_m;
    bit         pop;
    bit         finished;
    logic [7:0] acc;
    logic       e;
    cnt      = 0;
    ovf_m    = 1'b0;
    finished = 1'b0;
    popped   = 0;
    acc      = 8'h00;
    q_c.delete();
    idle_low();
    tx_ready_c = 1'b0;
    collect_c  = 1'b1;
    tick();
    for (int k = 0; k < 600; k++) begin
      collect_c  = (k == retrig);
      tx_ready_c = (ready_mode == 1) ? 1'b1 :
                   (ready_mode == 2) ? ($urandom_range(3) != 0) : (k >= 180);
      if (k < 160) begin
        drive_bit(1'($urandom_range(1)), e);
        acc[k%8] = e;
      end else begin
        dynamics = 1'b0;
      end
      checks++;
      if (tx_valid_c !== (cnt > 0)) begin
        errors++;
        $display("FAIL c_valid k=%0d got %b want %b", k, tx_valid_c, cnt > 0);
      end
      if (cnt > 0) begin
        checks++;
        if (tx_data_c !== q_c[0]) begin
          errors++;
          $display("FAIL c_data k=%0d got %h want %h", k, tx_data_c, q_c[0]);
        end
      end
      checks++;
      if (overflow_c !== ovf_m || busy_c !== 1'b1) begin
        errors++;
        $display("FAIL c_flags k=%0d got ovf=%b busy=%b want %b 1", k, overflow_c, busy_c, ovf_m);
      end
      checks++;
      if (done_c !== (k >= 160 && cnt == 0)) begin
        errors++;
        $display("FAIL c_done k=%0d got %b want %b", k, done_c, k >= 160 && cnt == 0);
      end
      if (k == rst_at) begin
        reset = 1'b1;
        tick();
        checks++;
        if ({tx_valid_c, tx_data_c, busy_c, done_c, overflow_c} !== 12'h0) begin
          errors++;
          $display("FAIL rst_mid got %h want 0", {tx_valid_c, tx_data_c, busy_c, done_c,
                                                   overflow_c});
        end
        reset     = 1'b0;
        collect_c = 1'b0;
        for (int j = 0; j < 8; j++) begin
          tick();
          checks++;
          if (done_c !== 1'b0 || busy_c !== 1'b0 || tx_valid_c !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet j=%0d got done=%b busy=%b valid=%b want 0 0 0", j, done_c,
                     busy_c, tx_valid_c);
          end
        end
        q_c.delete();
        return;
      end
      cnt_pre = cnt;
      pop     = tx_ready_c && (cnt > 0);
      if (pop) begin
        void'(q_c.pop_front());
        cnt--;
        popped++;
      end
      if (k < 160 && k % 8 == 7) begin
        if (cnt_pre < 16 || pop) begin
          q_c.push_back(acc);
          cnt++;
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (k >= 160 && cnt_pre == 0) begin
        tick();
        checks++;
        if (busy_c !== 1'b0 || done_c !== 1'b0 || tx_valid_c !== 1'b0) begin
          errors++;
          $display("FAIL c_end got busy=%b done=%b valid=%b want 0 0 0", busy_c, done_c,
                   tx_valid_c);
        end
        finished = 1'b1;
        break;
      end
      tick();
    end
    collect_c  = 1'b0;
    tx_ready_c = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL c_timeout got no done within 600 cycles want done");
    end
  endtask

  task automatic test_overflow();
    int popped;
    run_c(0, -1, -1, popped);
    checks++;
    if (popped != 16) begin
      errors++;
      $display("FAIL ovf_emitted got %0d want 16", popped);
    end
  endtask

  task automatic test_reset_mid_run();
    int popped;
    run_c(0, -1, 12, popped);
    run_c(1, -1, -1, popped);
    checks++;
    if (popped != 20) begin
      errors++;
      $display("FAIL rst_rerun_emitted got %0d want 20", popped);
    end
  endtask

  task automatic test_restart_ignored();
    int popped;
    run_c(1, 40, -1, popped);
    checks++;
    if (popped != 20) begin
      errors++;
      $display("FAIL retrig_emitted got %0d want 20", popped);
    end
  endtask

  task automatic test_back_to_back();
    int popped;
    for (int r = 0; r < 2; r++) begin
      run_c(2, -1, -1, popped);
      checks++;
      if (popped != 20) begin
        errors++;
        $display("FAIL b2b_emitted run=%0d got %0d want 20", r, popped);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    dynamics   = 1'b0;
    hist       = 2'b00;
    collect_a  = 1'b0;
    collect_b  = 1'b0;
    collect_c  = 1'b0;
    tx_ready_a = 1'b0;
    tx_ready_b = 1'b0;
    tx_ready_c = 1'b0;
    test_reset();
    test_pattern();
    test_sample_div();
    test_overflow();
    test_reset_mid_run();
    test_restart_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
